// File: rtl/l2_arbiter.sv
// Purpose: arbitrate the single L2 cacheline port between the L1 I-cache (read-only) and the L1 D-cache (read/write).
// Latency: the L2 request is registered one cycle after a request is seen in IDLE; the L1 response is combinational with l2_mem_resp.
// Backpressure: one transaction at a time; requesters hold their request until resp, and an IDLE bubble separates transactions.
// Optional per-requester grant counters are built when the macro L2_ARB_PERF_CNT_EN is defined; otherwise the counter outputs are tied to 0.
module l2_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_mem_read,
    input  logic [15:0]    i_mem_address,
    output logic [127:0]   i_mem_rdata,
    output logic           i_mem_resp,
    input  logic           d_mem_read,
    input  logic           d_mem_write,
    input  logic [15:0]    d_mem_address,
    input  logic [127:0]   d_mem_wdata,
    output logic [127:0]   d_mem_rdata,
    output logic           d_mem_resp,
    output logic           l2_mem_read,
    output logic           l2_mem_write,
    output logic [15:0]    l2_mem_address,
    output logic [127:0]   l2_mem_wdata,
    input  logic [127:0]   l2_mem_rdata,
    input  logic           l2_mem_resp,
    output logic [15:0]    i_grant_cnt,
    output logic [15:0]    d_grant_cnt
);

    // Wide enough to hold the value MAX_WAIT itself.
    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t         state;
    logic [WCW-1:0] wait_cnt;
    logic           d_req;
    logic           i_starved;
    logic           grant_i;
    logic           grant_d;

    assign d_req = d_mem_read | d_mem_write;

    // Grant decision made in IDLE: D wins by default unless I has been overtaken MAX_WAIT times.
    always_comb begin
        i_starved = (wait_cnt == WAIT_MAX);
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        if (state == IDLE) begin
            grant_i = i_mem_read & (~d_req | i_starved);
            grant_d = d_req & ~(i_mem_read & i_starved);
        end
    end

    // FSM with registered L2 request; the request registers double as the latched address/wdata/op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            l2_mem_read    <= 1'b0;
            l2_mem_write   <= 1'b0;
            l2_mem_address <= '0;
            l2_mem_wdata   <= '0;
            wait_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state          <= SERVE_I;
                        l2_mem_read    <= 1'b1;
                        l2_mem_write   <= 1'b0;
                        l2_mem_address <= i_mem_address;
                        l2_mem_wdata   <= '0;
                        wait_cnt       <= '0;
                    end else if (grant_d) begin
                        // Write wins when the D-cache illegally raises both read and write.
                        state          <= SERVE_D;
                        l2_mem_read    <= ~d_mem_write;
                        l2_mem_write   <= d_mem_write;
                        l2_mem_address <= d_mem_address;
                        l2_mem_wdata   <= d_mem_write ? d_mem_wdata : '0;
                        if (!i_mem_read) begin
                            wait_cnt <= '0;
                        end else if (!i_starved) begin
                            wait_cnt <= wait_cnt + WCW'(1);
                        end
                    end else if (!i_mem_read) begin
                        wait_cnt <= '0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    // Completion returns to IDLE, which drops the L2 request and gives the bubble cycle.
                    if (l2_mem_resp) begin
                        state          <= IDLE;
                        l2_mem_read    <= 1'b0;
                        l2_mem_write   <= 1'b0;
                        l2_mem_address <= '0;
                        l2_mem_wdata   <= '0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    l2_mem_read    <= 1'b0;
                    l2_mem_write   <= 1'b0;
                    l2_mem_address <= '0;
                    l2_mem_wdata   <= '0;
                end
            endcase
        end
    end

    // Response steering: only the requester being served sees resp and data, and only in the L2 resp cycle.
    always_comb begin
        i_mem_resp  = (state == SERVE_I) & l2_mem_resp;
        d_mem_resp  = (state == SERVE_D) & l2_mem_resp;
        i_mem_rdata = i_mem_resp ? l2_mem_rdata : '0;
        d_mem_rdata = d_mem_resp ? l2_mem_rdata : '0;
    end

`ifdef L2_ARB_PERF_CNT_EN
    // Grant counters, bumped on each grant edge and left to wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_grant_cnt <= '0;
            d_grant_cnt <= '0;
        end else begin
            if (grant_i) begin
                i_grant_cnt <= i_grant_cnt + 16'd1;
            end
            if (grant_d) begin
                d_grant_cnt <= d_grant_cnt + 16'd1;
            end
        end
    end
`else
    assign i_grant_cnt = '0;
    assign d_grant_cnt = '0;
`endif

    // Both requesters must never be answered together.
    a_one_resp: assert property (@(posedge clk) disable iff (!rst_n) !(i_mem_resp && d_mem_resp));

    // An open L2 request stays stable until L2 completes it.
    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (state != IDLE && !l2_mem_resp) |=> ($stable(l2_mem_address) && $stable(l2_mem_wdata)
                                            && $stable(l2_mem_read) && $stable(l2_mem_write)));

endmodule

// File: tb/tb_l2_arbiter.sv
// Purpose: randomized bench for l2_arbiter with a transaction-level arbitration model and scoreboard queues.
// Latency: expects the L2 request one cycle after a request is visible in IDLE, and two cycles after a completion.
// Backpressure: requesters hold until resp; an L2 model answers after a random delay and sometimes pulses resp while idle.
module tb_l2_arbiter;

    localparam int MAX_WAIT = 2;

    logic         clk;
    logic         rst_n;
    logic         i_mem_read;
    logic [15:0]  i_mem_address;
    logic [127:0] i_mem_rdata;
    logic         i_mem_resp;
    logic         d_mem_read;
    logic         d_mem_write;
    logic [15:0]  d_mem_address;
    logic [127:0] d_mem_wdata;
    logic [127:0] d_mem_rdata;
    logic         d_mem_resp;
    logic         l2_mem_read;
    logic         l2_mem_write;
    logic [15:0]  l2_mem_address;
    logic [127:0] l2_mem_wdata;
    logic [127:0] l2_mem_rdata;
    logic         l2_mem_resp;
    logic [15:0]  i_grant_cnt;
    logic [15:0]  d_grant_cnt;

    l2_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_mem_read     (i_mem_read),
        .i_mem_address  (i_mem_address),
        .i_mem_rdata    (i_mem_rdata),
        .i_mem_resp     (i_mem_resp),
        .d_mem_read     (d_mem_read),
        .d_mem_write    (d_mem_write),
        .d_mem_address  (d_mem_address),
        .d_mem_wdata    (d_mem_wdata),
        .d_mem_rdata    (d_mem_rdata),
        .d_mem_resp     (d_mem_resp),
        .l2_mem_read    (l2_mem_read),
        .l2_mem_write   (l2_mem_write),
        .l2_mem_address (l2_mem_address),
        .l2_mem_wdata   (l2_mem_wdata),
        .l2_mem_rdata   (l2_mem_rdata),
        .l2_mem_resp    (l2_mem_resp),
        .i_grant_cnt    (i_grant_cnt),
        .d_grant_cnt    (d_grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One outstanding request per requester; since = first cycle it is visible to the arbiter.
    typedef struct {
        logic [15:0]  addr;
        logic         wr;
        logic [127:0] wdata;
        int           since;
    } req_t;

    req_t i_q[$];
    req_t d_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state
    int   serving   = 0;     // 0 none, 1 I, 2 D
    int   last_resp = -100;
    int   ovt       = 0;     // D grants that overtook the waiting I request
    int   n_i       = 0;
    int   n_d       = 0;
    req_t cur;

    // Stimulus state
    bit i_busy = 0;
    bit d_busy = 0;
    int i_gap  = 0;
    int d_gap  = 0;
    int l2_wait   = -1;
    int force_lat = -1;

    function automatic logic [127:0] line_of(input logic [15:0] a);
        if (a == 16'h1230) return {16{8'hA5}};
        return {a, ~a, a ^ 16'h3C3C, a + 16'd7, {a[7:0], a[15:8]}, ~a ^ 16'h1111, a, 16'hBEEF};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks = checks + 1;
        if (act !== expv) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: predicts each grant from the pending queues and checks every observable output.
    always @(negedge clk) begin : monitor
        bit pi;
        bit pd;
        int want;
        int t;
        int exp_c;
        logic [127:0] exp_line;
        cyc = cyc + 1;
        if (!rst_n) begin
            serving   = 0;
            last_resp = cyc;
            ovt       = 0;
            n_i       = 0;
            n_d       = 0;
        end else begin
            if (serving == 0) begin
                pi = (i_q.size() > 0) && (i_q[0].since <= cyc - 1);
                pd = (d_q.size() > 0) && (d_q[0].since <= cyc - 1);
                want = 0;
                if (pi && pd) want = (ovt == MAX_WAIT) ? 1 : 2;
                else if (pi)  want = 1;
                else if (pd)  want = 2;
                t = cyc;
                if (pd) t = d_q[0].since;
                if (pi && i_q[0].since < t) t = i_q[0].since;
                exp_c = (last_resp + 2 > t + 1) ? last_resp + 2 : t + 1;
                if (want != 0 && (l2_mem_read || l2_mem_write)) begin
                    chk("grant_cycle", 128'(cyc), 128'(exp_c));
                    if (want == 1) begin
                        cur = i_q.pop_front();
                        n_i = n_i + 1;
                        ovt = 0;
                    end else begin
                        cur = d_q.pop_front();
                        n_d = n_d + 1;
                        if (pi && ovt < MAX_WAIT) ovt = ovt + 1;
                    end
                    serving = want;
                end else if (want != 0 && cyc >= exp_c) begin
                    chk("grant_missing", 128'(l2_mem_read | l2_mem_write), 128'(1));
                end
            end
            if (serving != 0) begin
                chk("l2_op", 128'({l2_mem_read, l2_mem_write}), 128'({~cur.wr, cur.wr}));
                chk("l2_addr", 128'(l2_mem_address), 128'(cur.addr));
                chk("l2_wdata", l2_mem_wdata, cur.wdata);
                exp_line = l2_mem_resp ? line_of(cur.addr) : '0;
                chk("i_resp", 128'(i_mem_resp), 128'(serving == 1 && l2_mem_resp));
                chk("d_resp", 128'(d_mem_resp), 128'(serving == 2 && l2_mem_resp));
                chk("i_rdata", i_mem_rdata, (serving == 1) ? exp_line : 128'(0));
                chk("d_rdata", d_mem_rdata, (serving == 2) ? exp_line : 128'(0));
                if (l2_mem_resp) begin
                    serving   = 0;
                    last_resp = cyc;
                end
            end else begin
                chk("idle_l2_req", 128'({l2_mem_read, l2_mem_write, l2_mem_address}), 128'(0));
                chk("idle_l2_wdata", l2_mem_wdata, 128'(0));
                chk("idle_resp", 128'({i_mem_resp, d_mem_resp}), 128'(0));
                chk("idle_rdata", i_mem_rdata | d_mem_rdata, 128'(0));
            end
        end
    end

    task automatic issue_i(input logic [15:0] a);
        req_t r;
        r.addr = a; r.wr = 1'b0; r.wdata = '0; r.since = cyc + 1;
        i_q.push_back(r);
        i_mem_address = a;
        i_mem_read    = 1'b1;
        i_busy        = 1'b1;
    endtask

    task automatic issue_d(input logic [15:0] a, input logic wr, input logic [127:0] wd, input logic both);
        req_t r;
        r.addr = a; r.wr = wr; r.wdata = wr ? wd : '0; r.since = cyc + 1;
        d_q.push_back(r);
        d_mem_address = a;
        d_mem_write   = wr;
        d_mem_read    = ~wr | both;
        d_mem_wdata   = wr ? wd : '0;
        d_busy        = 1'b1;
    endtask

    // One clock: note responses at the falling edge, then drive requesters and the L2 model just after the rising edge.
    task automatic step();
        logic is_r;
        logic ds_r;
        @(negedge clk);
        is_r = i_mem_resp;
        ds_r = d_mem_resp;
        @(posedge clk);
        #1;
        if (i_gap > 0) i_gap = i_gap - 1;
        if (d_gap > 0) d_gap = d_gap - 1;
        if (is_r) begin
            i_mem_read    = 1'b0;
            i_mem_address = 16'($urandom);
            i_busy        = 1'b0;
            i_gap         = $urandom_range(0, 2);
        end
        if (ds_r) begin
            d_mem_read  = 1'b0;
            d_mem_write = 1'b0;
            d_busy      = 1'b0;
            d_gap       = $urandom_range(0, 2);
        end
        if (l2_mem_resp) begin
            l2_mem_resp  = 1'b0;
            l2_wait      = -1;
            l2_mem_rdata = {4{$urandom}};
        end else if (l2_mem_read || l2_mem_write) begin
            if (l2_wait < 0) l2_wait = (force_lat >= 0) ? force_lat : $urandom_range(0, 4);
            if (l2_wait == 0) begin
                l2_mem_resp  = 1'b1;
                l2_mem_rdata = line_of(l2_mem_address);
            end else begin
                l2_wait = l2_wait - 1;
            end
        end else begin
            l2_mem_rdata = {4{$urandom}};
            if ($urandom_range(0, 9) == 0) l2_mem_resp = 1'b1;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((i_busy || d_busy) && n < budget) begin
            step();
            n = n + 1;
        end
        chk("drain_timeout", 128'({i_busy, d_busy}), 128'(0));
    endtask

    initial begin
        logic wr;
        rst_n = 1'b0;
        i_mem_read = 1'b0; i_mem_address = '0;
        d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = '0; d_mem_wdata = '0;
        l2_mem_rdata = '0; l2_mem_resp = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_l2", 128'({l2_mem_read, l2_mem_write, l2_mem_address}) | l2_mem_wdata, 128'(0));
        chk("reset_resp", 128'({i_mem_resp, d_mem_resp, i_grant_cnt, d_grant_cnt}), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed: lone I read, lone D write, then simultaneous reads (D first).
        force_lat = 5;
        issue_i(16'h1230);
        wait_idle(50);
        force_lat = -1;
        issue_d(16'h4440, 1'b1, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b0);
        wait_idle(50);
        issue_d(16'h2000, 1'b0, '0, 1'b0);
        issue_i(16'h3000);
        wait_idle(50);

        // Starvation: I and D both re-request immediately after every completion.
        for (int k = 0; k < 150; k++) begin
            step();
            if (!i_busy) issue_i(16'($urandom));
            if (!d_busy) begin
                wr = 1'($urandom_range(0, 1));
                issue_d(16'($urandom), wr, {4{$urandom}}, 1'b0);
            end
        end
        wait_idle(100);

        // Asynchronous reset while D is being served; the held I request must win right after release.
        issue_d(16'h5550, 1'b0, '0, 1'b0);
        issue_i(16'h6660);
        force_lat = 8;
        step();
        chk("serve_d_before_reset", 128'({l2_mem_read, l2_mem_write, l2_mem_address}), 128'({2'b10, 16'h5550}));
        #3 rst_n = 1'b0;
        d_mem_read = 1'b0; d_mem_write = 1'b0; d_busy = 1'b0; d_q.delete();
        l2_mem_resp = 1'b0; l2_wait = -1;
        #1;
        chk("rst_l2_req", 128'({l2_mem_read, l2_mem_write, l2_mem_address}), 128'(0));
        chk("rst_l2_wdata", l2_mem_wdata, 128'(0));
        chk("rst_resp", 128'({i_mem_resp, d_mem_resp}), 128'(0));
        chk("rst_rdata", i_mem_rdata | d_mem_rdata, 128'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        force_lat = -1;
        wait_idle(50);

        // Random traffic with gaps, writes and the occasional illegal read+write.
        for (int k = 0; k < 1500; k++) begin
            step();
            if (!i_busy && i_gap == 0 && $urandom_range(0, 3) == 0) issue_i(16'($urandom));
            if (!d_busy && d_gap == 0 && $urandom_range(0, 2) == 0) begin
                wr = 1'($urandom_range(0, 1));
                issue_d(16'($urandom), wr, {4{$urandom}}, wr && ($urandom_range(0, 7) == 0));
            end
        end
        wait_idle(100);
        repeat (3) step();

`ifdef L2_ARB_PERF_CNT_EN
        chk("i_grant_cnt", 128'(i_grant_cnt), 128'(16'(n_i)));
        chk("d_grant_cnt", 128'(d_grant_cnt), 128'(16'(n_d)));
`else
        chk("i_grant_cnt", 128'(i_grant_cnt), 128'(0));
        chk("d_grant_cnt", 128'(d_grant_cnt), 128'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
